// File: rtl/sfir_coeff_loader_if.sv
// Coefficient stream handshake between a coefficient source and the loader.
interface sfir_coeff_loader_if #(
  parameter int unsigned COEF_WIDTH = 16
) ();
  logic [COEF_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/sfir_coeff_loader.sv
// Coefficient loader for the symmetric systolic FIR: collects a full set in a
// shadow bank and swaps it into the active bank on a single edge.
module sfir_coeff_loader #(
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned TAPS       = 8
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       start_i,
  sfir_coeff_loader_if.slave         coeff_s,
  output logic [TAPS*COEF_WIDTH-1:0] coeff_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int unsigned CntW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TAPS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StCommit} state_e;

  state_e                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [TAPS*COEF_WIDTH-1:0] shadow_q, shadow_d;
  logic [TAPS*COEF_WIDTH-1:0] coeff_q, coeff_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  // Next-state logic: beat capture, set-length checking and the commit swap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    coeff_d  = coeff_q;
    done_d   = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StLoad;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      StLoad: begin
        if (coeff_s.tvalid) begin
          for (int unsigned k = 0; k < TAPS; k++) begin
            if (cnt_q == CntW'(k)) begin
              shadow_d[k*COEF_WIDTH +: COEF_WIDTH] = coeff_s.tdata;
            end
          end
          cnt_d = cnt_q + CntW'(1);
          if ((cnt_q == LastCnt) && coeff_s.tlast) begin
            state_d = StCommit;
            cnt_d   = '0;
          end else if ((cnt_q == LastCnt) || coeff_s.tlast) begin
            // Short or long set: drop the partial bank, keep the active one.
            state_d  = StIdle;
            cnt_d    = '0;
            shadow_d = '0;
            err_d    = 1'b1;
          end
        end
      end
      StCommit: begin
        coeff_d = shadow_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and bank registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shadow_q <= '0;
      coeff_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      coeff_q  <= coeff_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign coeff_s.tready = (state_q == StLoad);
  assign busy_o         = (state_q != StIdle);
  assign coeff_o        = coeff_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_sfir_coeff_loader.sv
// Directed bench for sfir_coeff_loader with TAPS=8, COEF_WIDTH=16.
module tb_sfir_coeff_loader;

  localparam int unsigned W  = 16;
  localparam int unsigned T  = 8;
  localparam int unsigned BW = W * T;

  logic          clk_i;
  logic          rstn_i;
  logic          start_i;
  logic [BW-1:0] coeff_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  int n_pass;
  int n_total;

  sfir_coeff_loader_if #(.COEF_WIDTH(W)) coeff_if ();

  sfir_coeff_loader #(
    .COEF_WIDTH(W),
    .TAPS      (T)
  ) u_dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .start_i(start_i),
    .coeff_s(coeff_if),
    .coeff_o(coeff_o),
    .busy_o (busy_o),
    .done_o (done_o),
    .err_o  (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Hand-written sets; tap k occupies bits [k*16 +: 16].
  // Set A: 1, -2, 3, -4, 5, -6, 7, -8
  localparam logic [BW-1:0] SetA =
    {16'hFFF8, 16'h0007, 16'hFFFA, 16'h0005, 16'hFFFC, 16'h0003, 16'hFFFE, 16'h0001};
  localparam logic [BW-1:0] SetB =
    {16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h0000, 16'hABCD, 16'h1234, 16'h8000, 16'h7FFF};

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Starts a load in the current cycle (cycle 0), streams nbeats words with
  // optional idle cycles before beat i (gaps[i]), then waits for done/err.
  task automatic run_load(input string tag, input logic [BW-1:0] vals, input int nbeats,
                          input int last_beat, input logic [7:0] gaps,
                          input logic [BW-1:0] prev, output int done_cyc, output int err_cyc);
    int cyc;
    done_cyc = 0;
    err_cyc  = 0;
    start_i  = 1'b1;
    tick();
    cyc     = 1;
    start_i = 1'b0;
    check({tag, ":busy_c1"}, BW'(busy_o), BW'(1));
    check({tag, ":tready_c1"}, BW'(coeff_if.tready), BW'(1));
    check({tag, ":err_c1"}, BW'(err_o), BW'(0));
    for (int i = 0; i < nbeats; i++) begin
      if (gaps[i]) begin
        coeff_if.tvalid = 1'b0;
        coeff_if.tlast  = 1'b0;
        tick();
        cyc++;
      end
      check({tag, ":coeff_hold"}, coeff_o, prev);
      check({tag, ":done_low"}, BW'(done_o), BW'(0));
      coeff_if.tvalid = 1'b1;
      coeff_if.tdata  = vals[i*W +: W];
      coeff_if.tlast  = (i == last_beat);
      tick();
      cyc++;
    end
    coeff_if.tvalid = 1'b0;
    coeff_if.tlast  = 1'b0;
    while (cyc <= 24) begin
      if (done_o || err_o) begin
        if (done_o) done_cyc = cyc;
        if (err_o) err_cyc = cyc;
        break;
      end
      check({tag, ":coeff_hold_tail"}, coeff_o, prev);
      tick();
      cyc++;
    end
    check({tag, ":done_err_excl"}, BW'(done_o & err_o), BW'(0));
  endtask

  initial begin
    int dc;
    int ec;
    n_pass          = 0;
    n_total         = 0;
    rstn_i          = 1'b0;
    start_i         = 1'b0;
    coeff_if.tdata  = '0;
    coeff_if.tvalid = 1'b0;
    coeff_if.tlast  = 1'b0;
    #12;
    check("rst:coeff", coeff_o, '0);
    check("rst:tready", BW'(coeff_if.tready), BW'(0));
    check("rst:busy", BW'(busy_o), BW'(0));
    check("rst:done", BW'(done_o), BW'(0));
    check("rst:err", BW'(err_o), BW'(0));
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick();

    // Valid without start must not be accepted.
    coeff_if.tvalid = 1'b1;
    coeff_if.tdata  = 16'h5555;
    coeff_if.tlast  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle:tready", BW'(coeff_if.tready), BW'(0));
      check("idle:busy", BW'(busy_o), BW'(0));
      check("idle:coeff", coeff_o, '0);
      check("idle:done", BW'(done_o), BW'(0));
    end
    coeff_if.tvalid = 1'b0;
    coeff_if.tlast  = 1'b0;
    tick();

    // Normal load.
    run_load("norm", SetA, 8, 7, 8'h00, '0, dc, ec);
    check("norm:done_cyc", BW'(dc), BW'(10));
    check("norm:err_cyc", BW'(ec), BW'(0));
    check("norm:coeff", coeff_o, SetA);
    check("norm:tap0", BW'(coeff_o[0 +: W]), BW'(16'h0001));
    check("norm:tap7", BW'(coeff_o[7*W +: W]), BW'(16'hFFF8));
    check("norm:busy", BW'(busy_o), BW'(0));
    tick();
    check("norm:done_pulse", BW'(done_o), BW'(0));

    // Throttled source: idle cycles before beats 1, 3 and 6.
    run_load("thr", SetB, 8, 7, 8'b0100_1010, SetA, dc, ec);
    check("thr:done_cyc", BW'(dc), BW'(13));
    check("thr:coeff", coeff_o, SetB);
    tick();

    // Short set: tlast on beat 5.
    run_load("short", SetA, 5, 4, 8'h00, SetB, dc, ec);
    check("short:err_cyc", BW'(ec), BW'(6));
    check("short:done_cyc", BW'(dc), BW'(0));
    check("short:busy", BW'(busy_o), BW'(0));
    check("short:coeff", coeff_o, SetB);
    tick();
    check("short:err_sticky", BW'(err_o), BW'(1));
    check("short:no_done", BW'(done_o), BW'(0));

    // Long set: eight beats without tlast; also confirms start clears err.
    run_load("long", SetA, 8, -1, 8'h00, SetB, dc, ec);
    check("long:err_cyc", BW'(ec), BW'(9));
    check("long:done_cyc", BW'(dc), BW'(0));
    check("long:coeff", coeff_o, SetB);
    check("long:tready", BW'(coeff_if.tready), BW'(0));
    tick();

    // Reset in the middle of a load.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      coeff_if.tvalid = 1'b1;
      coeff_if.tdata  = SetA[i*W +: W];
      tick();
    end
    coeff_if.tvalid = 1'b0;
    #2;
    rstn_i = 1'b0;
    #1;
    check("mrst:coeff", coeff_o, '0);
    check("mrst:tready", BW'(coeff_if.tready), BW'(0));
    check("mrst:busy", BW'(busy_o), BW'(0));
    check("mrst:done", BW'(done_o), BW'(0));
    check("mrst:err", BW'(err_o), BW'(0));
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick();

    run_load("post", SetA, 8, 7, 8'h00, '0, dc, ec);
    check("post:done_cyc", BW'(dc), BW'(10));
    check("post:coeff", coeff_o, SetA);
    // Back-to-back: start raised in the done cycle.
    run_load("b2b", SetB, 8, 7, 8'h00, SetA, dc, ec);
    check("b2b:done_cyc", BW'(dc), BW'(10));
    check("b2b:coeff", coeff_o, SetB);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sfir_coeff_loader.md
# sfir_coeff_loader

Coefficient writer for the even-symmetric systolic FIR chain. Accepts a stream of unique coefficients (half the symmetric filter length) over a valid/ready handshake and collects them in a shadow bank. It then commits the complete set to the active bank in a single clock edge, so the per-tap `coeff_i` ports never see a mix of old and new coefficients. Malformed loads are rejected and leave the active set untouched.

## Interface
- `COEF_WIDTH`, default 16: bit width of one signed coefficient.
- `TAPS`, default 8: number of unique coefficients, one per systolic element; must be ≥ 2.
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  request a new load; sampled only in IDLE.
- `coeff_tdata_i`  in  COEF_WIDTH  signed coefficient word. The first beat is tap 0.
- `coeff_tvalid_i`  in  1  source has a word.
- `coeff_tlast_i`  in  1  marks the final word of the set.
- `coeff_tready_o`  out  1  loader accepts a word; a beat transfers when valid and ready are both high.
- `coeff_o`  out  TAPS*COEF_WIDTH  active coefficient bank; tap k is at bits [k*COEF_WIDTH +: COEF_WIDTH].
- `busy_o`  out  1  high when the state is not IDLE.
- `done_o`  out  1  one-cycle pulse when a new set becomes active.
- `err_o`  out  1  sticky load error; cleared when the next load is accepted.

## Operation
- States: IDLE, LOAD, COMMIT. A beat counter `cnt` runs from 0 to TAPS-1. The shadow bank holds TAPS×COEF_WIDTH bits.
- IDLE:
  - `coeff_tready_o` = 0.
  - `start_i` = 1 → go to LOAD, set `cnt` = 0, clear `err_o`.
- LOAD:
  - `coeff_tready_o` = 1.
  - Each accepted beat writes shadow[cnt] and increments `cnt`.
  - Beat accepted with `cnt` = TAPS-1 and `tlast` = 1 → COMMIT.
  - Beat accepted with `cnt` < TAPS-1 and `tlast` = 1 (short set) → set `err_o`, go to IDLE.
  - Beat accepted with `cnt` = TAPS-1 and `tlast` = 0 (long set) → set `err_o`, go to IDLE. The loader does not consume the remaining words of that packet.
  - In both error cases the shadow contents are discarded, `coeff_o` is unchanged and `done_o` stays low.
  - `tvalid` = 0 inserts wait cycles; there is no timeout.
- COMMIT:
  - `coeff_tready_o` = 0.
  - On the exit edge: `coeff_o` ← shadow (all taps on the same edge), `done_o` ← 1 for one cycle, state → IDLE.
- `start_i` is ignored in LOAD and COMMIT.
- Coefficients pass through unmodified: no sign extension, no rounding, no reordering.

## Timing
- Reset values (asynchronous assert, synchronous-safe release):
  - state = IDLE, `cnt` = 0.
  - `coeff_o` = all zeros, shadow = all zeros.
  - `coeff_tready_o` = 0, `busy_o` = 0, `done_o` = 0, `err_o` = 0.
- Reset asserted mid-LOAD or in COMMIT discards the partial set; `coeff_o` returns to zero.
- Cycle-level timing from `start_i` sampled high in IDLE at cycle 0:
  - cycle 1: LOAD, `tready` = 1, `busy_o` = 1.
  - cycles 1..TAPS: beats accepted when `tvalid` is held high.
  - cycle TAPS+1: COMMIT.
  - cycle TAPS+2: new `coeff_o` visible, `done_o` = 1, state IDLE, `busy_o` = 0.
- Minimum load-to-active latency is TAPS+2 cycles. Each idle source cycle adds one.
- `start_i` is accepted again in the same cycle that `done_o` is high, giving back-to-back loads.
- On an error-terminating beat at cycle t: `err_o` = 1 and state = IDLE from cycle t+1.
- `done_o` and `err_o` are never high together.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset then idle (TAPS=8): check `coeff_o` = 0, `tready` = 0, `busy` = 0, `done` = 0, `err` = 0. Drive `tvalid` = 1 without `start_i` → no beat is accepted.
- Normal load (TAPS=8): start, then 8 continuous beats 1, -2, 3, …, -8 with `tlast` on beat 8 → `done_o` pulses exactly at cycle 10. `coeff_o` tap0 = 16'h0001, tap7 = 16'hFFF8. `coeff_o` is unchanged before cycle 10.
- Throttled source: insert 3 random `tvalid` = 0 gaps → `done_o` at cycle 13 with the same contents. `coeff_o` holds the old set throughout the load.
- Short set: `tlast` on beat 5 → `err_o` = 1, state IDLE, `coeff_o` keeps the previous set, no `done_o`. The next start clears `err_o`.
- Long set: 8 beats with no `tlast` → `err_o` = 1 after beat 8, previous set retained.
- Reset mid-LOAD after 4 beats → all outputs at reset values. A following full load commits normally. Back-to-back: `start_i` asserted in the `done_o` cycle is accepted.
